// File: rtl/sys_ctrl.sv
// Command sequencer: decodes framed RX bytes into register-file writes/reads and
// ALU operations, then returns read data or ALU results over the TX byte handshake.
module sys_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter int                ALU_W       = 16,
  parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] RF_RD_DATA,
  input  logic              RF_RD_VLD,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VLD,
  input  logic              TX_BUSY,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic              RF_WR_EN,
  output logic              RF_RD_EN,
  output logic [DATA_W-1:0] RF_WR_DATA,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  output logic              CLK_GATE_EN,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A, S_OP_B,
    S_ALU_FUN, S_ALU_WAIT, S_TX_LSB, S_TX_MSB, S_TX_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              alu_en_q, alu_en_d;
  logic [3:0]        alu_fun_q, alu_fun_d;
  logic              clk_gate_en_q, clk_gate_en_d;
  logic [DATA_W-1:0] tx_p_data_q, tx_p_data_d;
  logic              tx_d_vld_q, tx_d_vld_d;
  logic [ALU_W-1:0]  result_q, result_d;
  logic              two_byte_q, two_byte_d;
  logic              alu_go_q, alu_go_d;     // gate is up, ALU_EN due next cycle
  logic              busy_seen_q, busy_seen_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    rf_addr_d     = rf_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    alu_fun_d     = alu_fun_q;
    clk_gate_en_d = clk_gate_en_q;
    tx_p_data_d   = tx_p_data_q;
    result_d      = result_q;
    two_byte_d    = two_byte_q;
    alu_go_d      = alu_go_q;
    busy_seen_d   = busy_seen_q;
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    alu_en_d      = 1'b0;
    tx_d_vld_d    = 1'b0;

    case (state_q)
      S_IDLE: if (RX_D_VLD) begin
        if      (RX_P_DATA == CMD_WR)      state_d = S_WR_ADDR;
        else if (RX_P_DATA == CMD_RD)      state_d = S_RD_ADDR;
        else if (RX_P_DATA == CMD_ALU_OP)  state_d = S_OP_A;
        else if (RX_P_DATA == CMD_ALU_NOP) state_d = S_ALU_FUN;
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR_W-1:0];
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        rf_wr_en_d   = 1'b1;
        rf_wr_data_d = RX_P_DATA;
        state_d      = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        rf_rd_en_d = 1'b1;
        rf_addr_d  = RX_P_DATA[ADDR_W-1:0];
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: if (RF_RD_VLD) begin
        result_d   = {{(ALU_W-DATA_W){1'b0}}, RF_RD_DATA};
        two_byte_d = 1'b0;
        state_d    = S_TX_LSB;
      end
      S_OP_A, S_OP_B: if (RX_D_VLD) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = (state_q == S_OP_A) ? ADDR_W'(0) : ADDR_W'(1);
        rf_wr_data_d = RX_P_DATA;
        state_d      = (state_q == S_OP_A) ? S_OP_B : S_ALU_FUN;
      end
      S_ALU_FUN: begin
        if (alu_go_q) begin
          alu_en_d = 1'b1;
          alu_go_d = 1'b0;
          state_d  = S_ALU_WAIT;
        end else if (RX_D_VLD) begin
          alu_fun_d     = RX_P_DATA[3:0];
          clk_gate_en_d = 1'b1;
          alu_go_d      = 1'b1;
        end
      end
      S_ALU_WAIT: if (ALU_OUT_VLD) begin
        result_d      = ALU_OUT;
        clk_gate_en_d = 1'b0;
        two_byte_d    = 1'b1;
        state_d       = S_TX_LSB;
      end
      S_TX_LSB: if (!TX_BUSY) begin
        tx_d_vld_d  = 1'b1;
        tx_p_data_d = result_q[DATA_W-1:0];
        busy_seen_d = 1'b0;
        state_d     = two_byte_q ? S_TX_MSB : S_TX_DONE;
      end
      // Both states hold until the transmitter has visibly taken the previous byte.
      S_TX_MSB, S_TX_DONE: begin
        if (!busy_seen_q) begin
          if (TX_BUSY) busy_seen_d = 1'b1;
        end else if (!TX_BUSY) begin
          busy_seen_d = 1'b0;
          if (state_q == S_TX_MSB) begin
            tx_d_vld_d  = 1'b1;
            tx_p_data_d = result_q[2*DATA_W-1:DATA_W];
            state_d     = S_TX_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      rf_addr_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      result_q      <= '0;
      two_byte_q    <= 1'b0;
      alu_go_q      <= 1'b0;
      busy_seen_q   <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      result_q      <= result_d;
      two_byte_q    <= two_byte_d;
      alu_go_q      <= alu_go_d;
      busy_seen_q   <= busy_seen_d;
    end
  end

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign TX_P_DATA   = tx_p_data_q;
  assign TX_D_VLD    = tx_d_vld_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: stimulus pushes expected strobes, a negedge
// monitor pops and compares them; register file, ALU and transmitter are modelled.
module tb_sys_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RF_RD_DATA = '0;
  logic       RF_RD_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic       ALU_OUT_VLD = 1'b0;
  logic       TX_BUSY = 1'b0;
  logic [3:0] RF_ADDR;
  logic       RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
  logic [7:0] RF_WR_DATA, TX_P_DATA;
  logic [3:0] ALU_FUN;

  sys_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_BUSY(TX_BUSY),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_ALU, EV_TX} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  ev_t        sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [16];
  logic [15:0] alu_value = '0;
  int         busy_len = 3;
  logic       tx_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic observe(input string name, input ev_kind_e k, input logic [7:0] a,
                         input logic [7:0] b);
    ev_t got, exp;
    got.kind = k; got.a = a; got.b = b;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected strobe got %h expected none at %0t", name, got, $time);
    end else begin
      exp = sb.pop_front();
      check(name, 32'(got), 32'(exp));
    end
  endtask

  // Monitor: compares each strobe against the scoreboard, plus handshake rules.
  logic gate_prev = 1'b0, busy_prev = 1'b0, tx_idle_ok = 1'b1, tx_seen_hi = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      gate_prev = 1'b0; busy_prev = 1'b0; tx_idle_ok = 1'b1; tx_seen_hi = 1'b0;
    end else begin
      if (RF_WR_EN) observe("rf_write", EV_WR, 8'(RF_ADDR), RF_WR_DATA);
      if (RF_RD_EN) observe("rf_read", EV_RD, 8'(RF_ADDR), 8'h00);
      if (ALU_EN) begin
        observe("alu_en", EV_ALU, 8'(ALU_FUN), 8'h00);
        check("gate_leads_alu_en", {30'd0, gate_prev, CLK_GATE_EN}, 32'd3);
      end
      if (TX_D_VLD) begin
        observe("tx_byte", EV_TX, TX_P_DATA, 8'h00);
        check("gate_low_at_tx", 32'(CLK_GATE_EN), 32'd0);
        check("tx_ready", {30'd0, tx_idle_ok, busy_prev}, 32'd2);
        tx_idle_ok = 1'b0;
        tx_seen_hi = 1'b0;
      end
      if (TX_BUSY) tx_seen_hi = 1'b1;
      else if (tx_seen_hi) begin
        tx_idle_ok = 1'b1;
        tx_seen_hi = 1'b0;
      end
      gate_prev = CLK_GATE_EN;
      busy_prev = TX_BUSY;
    end
  end

  // Register file: writes land immediately, reads answer two cycles after RF_RD_EN.
  always begin
    logic [3:0] ra;
    @(posedge CLK); #1;
    if (!RST && RF_WR_EN) mem[RF_ADDR] = RF_WR_DATA;
    if (!RST && RF_RD_EN) begin
      ra = RF_ADDR;
      repeat (2) @(posedge CLK);
      #1;
      RF_RD_DATA = mem[ra];
      RF_RD_VLD  = 1'b1;
      @(posedge CLK); #1;
      RF_RD_VLD  = 1'b0;
    end
  end

  // ALU: result four cycles after ALU_EN.
  always begin
    @(posedge CLK); #1;
    if (!RST && ALU_EN) begin
      repeat (4) @(posedge CLK);
      #1;
      ALU_OUT     = alu_value;
      ALU_OUT_VLD = 1'b1;
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
    end
  end

  // Transmitter: busy rises one cycle after the strobe, held for busy_len cycles.
  always begin
    @(posedge CLK); #1;
    if (!RST && TX_D_VLD) begin
      tx_pending = 1'b1;
      @(posedge CLK); #1;
      TX_BUSY = 1'b1;
      repeat (busy_len) @(posedge CLK);
      #1;
      TX_BUSY    = 1'b0;
      tx_pending = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || tx_pending || TX_BUSY) && n < 500) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout with %0d events outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {3'd0, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN,
                 CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'd0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[3] = 8'h77;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("reset_outputs");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Plain register write, no TX response.
    expect_ev(EV_WR, 8'h05, 8'h3C);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_idle("write_5");

    // Reset aborts a half-received write; the next read must see no stale write.
    send_byte(8'hAA); send_byte(8'h03);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("mid_frame_reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    expect_ev(EV_RD, 8'h03, 8'h00);
    expect_ev(EV_TX, 8'h77, 8'h00);
    send_byte(8'hBB); send_byte(8'h03);
    wait_idle("read_3_after_reset");

    // Read back the earlier write.
    expect_ev(EV_RD, 8'h05, 8'h00);
    expect_ev(EV_TX, 8'h3C, 8'h00);
    send_byte(8'hBB); send_byte(8'h05);
    wait_idle("read_5");

    // ALU with operands.
    alu_value = 16'h000D;
    expect_ev(EV_WR, 8'h00, 8'h0A);
    expect_ev(EV_WR, 8'h01, 8'h03);
    expect_ev(EV_ALU, 8'h00, 8'h00);
    expect_ev(EV_TX, 8'h0D, 8'h00);
    expect_ev(EV_TX, 8'h00, 8'h00);
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
    wait_idle("alu_op");
    check("gate_low_after_alu_op", 32'(CLK_GATE_EN), 32'd0);

    // ALU without operands against a slow transmitter.
    busy_len  = 20;
    alu_value = 16'hFFF0;
    expect_ev(EV_ALU, 8'h07, 8'h00);
    expect_ev(EV_TX, 8'hF0, 8'h00);
    expect_ev(EV_TX, 8'hFF, 8'h00);
    send_byte(8'hDD); send_byte(8'h07);
    wait_idle("alu_nop_slow_tx");
    check("gate_low_after_alu_nop", 32'(CLK_GATE_EN), 32'd0);
    busy_len = 3;

    // Unknown command byte ignored, then a single write.
    expect_ev(EV_WR, 8'h01, 8'h02);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    wait_idle("junk_then_write");

    // A byte arriving during ALU_WAIT is dropped, not queued.
    alu_value = 16'h1234;
    expect_ev(EV_ALU, 8'h03, 8'h00);
    expect_ev(EV_TX, 8'h34, 8'h00);
    expect_ev(EV_TX, 8'h12, 8'h00);
    send_byte(8'hDD); send_byte(8'h03); send_byte(8'hAA);
    wait_idle("alu_wait_drop");

    expect_ev(EV_WR, 8'h02, 8'h55);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h55);
    wait_idle("write_after_drop");
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command sequencer between the UART receiver, register file, ALU and UART transmitter, all on the REF_CLK domain.
- Decodes framed command bytes from RX, then drives register-file writes/reads and ALU operations.
- Returns read data or ALU results to the host through the TX byte handshake.
- Gates the ALU clock so the ALU clocks only while an operation is in flight.

Parameters:
- DATA_W, 8, width of RX/TX/register-file data bytes
- ADDR_W, 4, register-file address width
- ALU_W, 16, ALU result width (sent as two bytes)
- CMD_WR, 8'hAA, register write: CMD, ADDR, DATA
- CMD_RD, 8'hBB, register read: CMD, ADDR
- CMD_ALU_OP, 8'hCC, ALU with operands: CMD, A, B, FUNC
- CMD_ALU_NOP, 8'hDD, ALU without operands: CMD, FUNC

Ports:
- CLK  in  1  system clock (REF_CLK domain)
- RST  in  1  synchronous, active-high reset
- RX_P_DATA  in  DATA_W  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- RF_RD_DATA  in  DATA_W  register-file read data
- RF_RD_VLD  in  1  one-cycle strobe, RF_RD_DATA valid
- ALU_OUT  in  ALU_W  ALU result
- ALU_OUT_VLD  in  1  one-cycle strobe, ALU_OUT valid
- TX_BUSY  in  1  transmitter busy
- RF_ADDR  out  ADDR_W  register-file address
- RF_WR_EN  out  1  write strobe
- RF_RD_EN  out  1  read strobe
- RF_WR_DATA  out  DATA_W  write data
- ALU_EN  out  1  ALU operation enable
- ALU_FUN  out  4  ALU function select
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_W  byte to transmit
- TX_D_VLD  out  1  one-cycle strobe, TX_P_DATA valid

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal address, function and result registers cleared. RST mid-command aborts it: no further strobes are issued and the partial frame is discarded.
- All outputs are registered. Strobes (RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD) last exactly one cycle.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB, TX_DONE.
- IDLE: act only on RX_D_VLD.
  - CMD_WR -> WR_ADDR; CMD_RD -> RD_ADDR; CMD_ALU_OP -> OP_A; CMD_ALU_NOP -> ALU_FUN.
  - Any other byte: ignore and stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_W-1:0] -> WR_DATA.
- WR_DATA: on RX_D_VLD, next cycle RF_WR_EN=1 with latched RF_ADDR and RF_WR_DATA=byte -> IDLE. No TX response.
- RD_ADDR: on RX_D_VLD, next cycle RF_RD_EN=1, RF_ADDR=byte -> RD_WAIT.
- RD_WAIT: on RF_RD_VLD, latch result low byte = RF_RD_DATA, single-byte response -> TX_LSB.
- OP_A: on RX_D_VLD, RF write of byte to address 0 -> OP_B.
- OP_B: on RX_D_VLD, RF write of byte to address 1 -> ALU_FUN.
- ALU_FUN: on RX_D_VLD, latch ALU_FUN=byte[3:0] and raise CLK_GATE_EN. One cycle later, pulse ALU_EN -> ALU_WAIT.
  - CLK_GATE_EN therefore leads ALU_EN by at least one cycle.
- ALU_WAIT: on ALU_OUT_VLD, latch ALU_OUT, drop CLK_GATE_EN, two-byte response -> TX_LSB.
- TX_LSB: wait while TX_BUSY=1. When TX_BUSY=0, pulse TX_D_VLD with the low byte.
  - Single-byte response -> TX_DONE.
  - Two-byte response -> TX_MSB, after TX_BUSY has risen and then fallen.
- TX_MSB: when TX_BUSY=0, pulse TX_D_VLD with ALU_OUT[15:8] -> TX_DONE.
- TX_DONE: wait for TX_BUSY rise then fall -> IDLE.
- RX_D_VLD arriving outside IDLE or an operand-collecting state (RD_WAIT, ALU_WAIT, TX_*) is dropped. It is not queued.
- RF_RD_VLD or ALU_OUT_VLD arriving outside its wait state is ignored.
- A TX_BUSY rise must be observed before TX_DONE or TX_MSB advance, so there is no back-to-back strobe on a stalled transmitter.

Test Plan:
- RST pulse mid-frame (after 8'hAA, 8'h03) -> all outputs 0; next frame 8'hBB, 8'h03 is decoded correctly and no stale write occurs.
- RX 8'hAA, 8'h05, 8'h3C -> exactly one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=8'h3C; TX_D_VLD never asserted.
- RX 8'hBB, 8'h05; model returns RF_RD_DATA=8'h3C after 2 cycles -> one RF_RD_EN with RF_ADDR=5, then one TX_D_VLD with TX_P_DATA=8'h3C.
- RX 8'hCC, 8'h0A, 8'h03, 8'h00; model ALU_OUT=16'h000D -> RF writes (0,8'h0A) and (1,8'h03); ALU_FUN=0; CLK_GATE_EN high before ALU_EN; TX bytes 8'h0D then 8'h00; CLK_GATE_EN low after ALU_OUT_VLD.
- RX 8'hDD, 8'h07 -> no RF write; ALU_EN with ALU_FUN=7; result 16'hFFF0 sent as 8'hF0 then 8'hFF. Hold TX_BUSY high for 20 cycles after each byte -> second TX_D_VLD waits for the TX_BUSY fall.
- RX 8'h55, then 8'hAA, 8'h01, 8'h02 -> 8'h55 ignored, a single write (1, 8'h02); an extra RX_D_VLD injected during ALU_WAIT of a later 8'hDD frame is dropped.
